// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
//   Shared definitions for the I/D external-memory arbiter: FSM state
//   encodings, requester IDs and the watchdog counter helper.
package mem_arb_pkg;

  typedef logic [1:0] arb_state_t;

  localparam arb_state_t ST_IDLE = 2'd0;
  localparam arb_state_t ST_BUSY = 2'd1;
  localparam arb_state_t ST_GAP  = 2'd2;

  localparam logic REQ_I = 1'b0;
  localparam logic REQ_D = 1'b1;

  localparam int CNT_W = 16;

  // Watchdog increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// rr_pick2
//   Combinational two-way round-robin select. Bit 0 of req is the I port,
//   bit 1 the D port. On a tie the port that was not granted last wins.
// Ports:
//   req   in   2  request vector {d, i}
//   last  in   1  ID of the most recently granted port
//   gnt   out  1  ID of the selected port (meaningful when any = 1)
//   any   out  1  at least one request present
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt,
  output logic       any
);

  always_comb begin
    gnt = REQ_I;
    case (req)
      2'b01:   gnt = REQ_I;
      2'b10:   gnt = REQ_D;
      2'b11:   gnt = ~last;
      default: gnt = REQ_I;
    endcase
  end

  assign any = |req;

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one line-wide external memory port between the instruction cache
//   (port I) and the data cache (port D). Whole-line transactions are
//   serialised with round-robin fairness; ack/data/err go only to the owner.
//   A watchdog aborts transactions that never see ext_mem_ack.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   i_*/d_* addr,cs,we,data_i requester line address, request, write flag, data
//   i_*/d_* ack,data_o,err   completion pulse, read data, timeout-abort pulse
//   ext_mem_addr/cs/we/data_o  memory-side request
//   ext_mem_data_i, ext_mem_ack memory-side response
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | no owner; picks a requester when any cs is high
// BUSY    | owner's request driven to memory, watchdog running
// GAP     | one dead cycle so the owner can drop cs before re-arbitration
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 256,
  parameter int TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic              i_cs,
  input  logic              d_cs,
  input  logic              i_we,
  input  logic              d_we,
  input  logic [DATA_W-1:0] i_data_i,
  input  logic [DATA_W-1:0] d_data_i,
  output logic              i_ack,
  output logic              d_ack,
  output logic [DATA_W-1:0] i_data_o,
  output logic [DATA_W-1:0] d_data_o,
  output logic              i_err,
  output logic              d_err,
  output logic [ADDR_W-1:0] ext_mem_addr,
  output logic              ext_mem_cs,
  output logic              ext_mem_we,
  output logic [DATA_W-1:0] ext_mem_data_o,
  input  logic [DATA_W-1:0] ext_mem_data_i,
  input  logic              ext_mem_ack
);

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  arb_state_t       state;
  logic             grant;
  logic             last_grant;
  logic [CNT_W-1:0] cnt;

  logic             pick_gnt;
  logic             pick_any;
  logic             busy;
  logic             owner_cs;

  rr_pick2 u_pick (
    .req  ({d_cs, i_cs}),
    .last (last_grant),
    .gnt  (pick_gnt),
    .any  (pick_any)
  );

  assign busy     = (state == ST_BUSY);
  assign owner_cs = (grant == REQ_D) ? d_cs : i_cs;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      grant      <= REQ_I;
      last_grant <= REQ_D;
      cnt        <= '0;
      i_err      <= 1'b0;
      d_err      <= 1'b0;
    end else begin
      i_err <= 1'b0;
      d_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pick_any) begin
            grant <= pick_gnt;
            cnt   <= '0;
            state <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          // Priority: memory ack, then requester abort, then watchdog.
          if (ext_mem_ack) begin
            last_grant <= grant;
            cnt        <= '0;
            state      <= ST_GAP;
          end else if (!owner_cs) begin
            last_grant <= grant;
            cnt        <= '0;
            state      <= ST_IDLE;
          end else if (cnt == TO_LAST) begin
            last_grant <= grant;
            cnt        <= '0;
            state      <= ST_GAP;
            if (grant == REQ_I) i_err <= 1'b1;
            else                d_err <= 1'b1;
          end else begin
            cnt <= sat_inc(cnt);
          end
        end
        ST_GAP: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Memory-side request is only driven in BUSY; zero elsewhere so reset
  // (which forces IDLE asynchronously) immediately clears every output.
  always_comb begin
    ext_mem_cs     = busy & owner_cs;
    ext_mem_addr   = '0;
    ext_mem_we     = 1'b0;
    ext_mem_data_o = '0;
    if (busy) begin
      if (grant == REQ_D) begin
        ext_mem_addr   = d_addr;
        ext_mem_we     = d_we;
        ext_mem_data_o = d_data_i;
      end else begin
        ext_mem_addr   = i_addr;
        ext_mem_we     = i_we;
        ext_mem_data_o = i_data_i;
      end
    end
  end

  // Ack passes straight through to the owner; read data is gated by ack so
  // the non-owner never sees memory data.
  assign i_ack    = busy & ext_mem_ack & (grant == REQ_I);
  assign d_ack    = busy & ext_mem_ack & (grant == REQ_D);
  assign i_data_o = i_ack ? ext_mem_data_i : '0;
  assign d_data_o = d_ack ? ext_mem_data_i : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  logic         clk;
  logic         rst;
  logic [31:0]  i_addr, d_addr;
  logic         i_cs, d_cs, i_we, d_we;
  logic [255:0] i_data_i, d_data_i;
  logic         i_ack, d_ack, i_err, d_err;
  logic [255:0] i_data_o, d_data_o;
  logic [31:0]  ext_mem_addr;
  logic         ext_mem_cs, ext_mem_we;
  logic [255:0] ext_mem_data_o, ext_mem_data_i;
  logic         ext_mem_ack;

  // Second instance with a short watchdog.
  logic         t_i_cs, t_d_cs, t_ack;
  logic         t_i_ack, t_d_ack, t_i_err, t_d_err;
  logic [255:0] t_i_data_o, t_d_data_o, t_mem_data_o;
  logic [31:0]  t_mem_addr;
  logic         t_mem_cs, t_mem_we;

  int n_cmp;
  int n_bad;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .i_addr(i_addr), .d_addr(d_addr), .i_cs(i_cs), .d_cs(d_cs),
    .i_we(i_we), .d_we(d_we), .i_data_i(i_data_i), .d_data_i(d_data_i),
    .i_ack(i_ack), .d_ack(d_ack), .i_data_o(i_data_o), .d_data_o(d_data_o),
    .i_err(i_err), .d_err(d_err),
    .ext_mem_addr(ext_mem_addr), .ext_mem_cs(ext_mem_cs), .ext_mem_we(ext_mem_we),
    .ext_mem_data_o(ext_mem_data_o), .ext_mem_data_i(ext_mem_data_i),
    .ext_mem_ack(ext_mem_ack)
  );

  mem_arbiter #(.TIMEOUT(8)) dut_to (
    .clk(clk), .rst(rst),
    .i_addr(i_addr), .d_addr(d_addr), .i_cs(t_i_cs), .d_cs(t_d_cs),
    .i_we(i_we), .d_we(d_we), .i_data_i(i_data_i), .d_data_i(d_data_i),
    .i_ack(t_i_ack), .d_ack(t_d_ack), .i_data_o(t_i_data_o), .d_data_o(t_d_data_o),
    .i_err(t_i_err), .d_err(t_d_err),
    .ext_mem_addr(t_mem_addr), .ext_mem_cs(t_mem_cs), .ext_mem_we(t_mem_we),
    .ext_mem_data_o(t_mem_data_o), .ext_mem_data_i(ext_mem_data_i),
    .ext_mem_ack(t_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    d_cs = 1'b1; d_we = 1'b1; i_we = 1'b1;
    d_addr = 32'hDEAD_0400; i_data_i = {8{32'hFFFF_FFFF}}; d_data_i = {8{32'h5555_5555}};
    ext_mem_ack = 1'b1; ext_mem_data_i = {32{8'hA5}};
    repeat (2) step;
    n_cmp++; if (ext_mem_cs !== 1'b0) begin n_bad++; $display("FAIL rst_cs: got %b want 0", ext_mem_cs); end
    n_cmp++; if (ext_mem_addr !== 32'h0) begin n_bad++; $display("FAIL rst_addr: got %h want 0", ext_mem_addr); end
    n_cmp++; if (ext_mem_data_o !== 256'h0) begin n_bad++; $display("FAIL rst_wdata: got %h want 0", ext_mem_data_o); end
    n_cmp++; if (ext_mem_we !== 1'b0) begin n_bad++; $display("FAIL rst_we: got %b want 0", ext_mem_we); end
    n_cmp++; if ({i_ack, d_ack, i_err, d_err} !== 4'b0) begin n_bad++; $display("FAIL rst_ack_err: got %b want 0000", {i_ack, d_ack, i_err, d_err}); end
    n_cmp++; if ({i_data_o, d_data_o} !== 512'h0) begin n_bad++; $display("FAIL rst_rdata: got %h/%h want 0", i_data_o, d_data_o); end
    n_cmp++; if (t_mem_cs !== 1'b0) begin n_bad++; $display("FAIL rst_t_cs: got %b want 0", t_mem_cs); end
    ext_mem_ack = 1'b0; d_cs = 1'b0; d_we = 1'b0; i_we = 1'b0;
    rst = 1'b0;
    step;
  endtask

  task automatic test_simultaneous;
    int exp_own [4] = '{0, 1, 0, 1};
    int gap;
    logic [31:0]  w32;
    logic [255:0] pat;
    i_addr = 32'h0000_0100; d_addr = 32'h0000_0200;
    i_cs = 1'b1; d_cs = 1'b1;
    step;
    for (int r = 0; r < 4; r++) begin
      n_cmp++;
      if (ext_mem_addr !== ((exp_own[r] == 1) ? 32'h200 : 32'h100)) begin
        n_bad++; $display("FAIL sim_owner_r%0d: got addr %h want %h", r, ext_mem_addr, (exp_own[r] == 1) ? 32'h200 : 32'h100);
      end
      step; step;
      w32 = 32'hC0DE_0000 + r;
      pat = {8{w32}};
      ext_mem_data_i = pat; ext_mem_ack = 1'b1;
      #1;
      n_cmp++;
      if (((exp_own[r] == 1) ? d_ack : i_ack) !== 1'b1) begin
        n_bad++; $display("FAIL sim_ack_r%0d: got i_ack=%b d_ack=%b want owner=1", r, i_ack, d_ack);
      end
      n_cmp++;
      if (((exp_own[r] == 1) ? i_ack : d_ack) !== 1'b0) begin
        n_bad++; $display("FAIL sim_other_ack_r%0d: got i_ack=%b d_ack=%b want other=0", r, i_ack, d_ack);
      end
      n_cmp++;
      if (((exp_own[r] == 1) ? d_data_o : i_data_o) !== pat || ((exp_own[r] == 1) ? i_data_o : d_data_o) !== 256'h0) begin
        n_bad++; $display("FAIL sim_data_r%0d: got i=%h d=%h", r, i_data_o, d_data_o);
      end
      step;
      ext_mem_ack = 1'b0;
      if (exp_own[r] == 1) d_cs = 1'b0; else i_cs = 1'b0;
      if (r == 3) begin
        i_cs = 1'b0; d_cs = 1'b0;
        repeat (2) step;
      end else begin
        gap = 0;
        for (int w = 0; w < 8 && ext_mem_cs !== 1'b1; w++) begin
          gap++;
          step;
          if (w == 0) begin
            if (exp_own[r] == 1) d_cs = 1'b1; else i_cs = 1'b1;
          end
        end
        n_cmp++;
        if (gap !== 2) begin n_bad++; $display("FAIL sim_gap_r%0d: got %0d idle cycles want 2", r, gap); end
      end
    end
  endtask

  task automatic test_single_read;
    int acks_d, acks_i, cs_low;
    d_addr = 32'h0000_0400; d_we = 1'b0;
    ext_mem_ack = 1'b1;
    #1;
    n_cmp++; if ({i_ack, d_ack} !== 2'b00) begin n_bad++; $display("FAIL idle_ack_ignored: got %b want 00", {i_ack, d_ack}); end
    ext_mem_ack = 1'b0;
    d_cs = 1'b1;
    #1;
    n_cmp++; if (ext_mem_cs !== 1'b0) begin n_bad++; $display("FAIL rd_cs_early: got %b want 0", ext_mem_cs); end
    step;
    n_cmp++; if (ext_mem_cs !== 1'b1 || ext_mem_addr !== 32'h400 || ext_mem_we !== 1'b0) begin
      n_bad++; $display("FAIL rd_grant: got cs=%b addr=%h we=%b want 1/400/0", ext_mem_cs, ext_mem_addr, ext_mem_we);
    end
    acks_d = 0; acks_i = 0; cs_low = 0;
    for (int j = 2; j <= 10; j++) begin
      step;
      if (j == 10) begin ext_mem_ack = 1'b1; ext_mem_data_i = {32{8'hA5}}; end
      #1;
      if (d_ack === 1'b1) acks_d++;
      if (i_ack === 1'b1) acks_i++;
      if (ext_mem_cs !== 1'b1) cs_low++;
      if (j == 10) begin
        n_cmp++;
        if (d_data_o !== {32{8'hA5}} || i_data_o !== 256'h0) begin
          n_bad++; $display("FAIL rd_data: got d=%h i=%h", d_data_o, i_data_o);
        end
      end
    end
    n_cmp++; if (acks_d !== 1 || acks_i !== 0 || cs_low !== 0) begin
      n_bad++; $display("FAIL rd_ack_count: got d=%0d i=%0d cs_low=%0d want 1/0/0", acks_d, acks_i, cs_low);
    end
    step;
    ext_mem_ack = 1'b0; d_cs = 1'b0;
    #1;
    n_cmp++; if (ext_mem_cs !== 1'b0 || d_ack !== 1'b0) begin
      n_bad++; $display("FAIL rd_gap: got cs=%b d_ack=%b want 0/0", ext_mem_cs, d_ack);
    end
    step; step;
  endtask

  task automatic test_write;
    logic [255:0] wd;
    wd = {8{32'h1234_5678}};
    i_addr = 32'h0000_0800; i_we = 1'b1; i_data_i = wd; d_cs = 1'b0;
    i_cs = 1'b1;
    step;
    for (int j = 0; j < 4; j++) begin
      n_cmp++;
      if (ext_mem_cs !== 1'b1 || ext_mem_we !== 1'b1 || ext_mem_data_o !== wd) begin
        n_bad++; $display("FAIL wr_pass_c%0d: got cs=%b we=%b data=%h", j, ext_mem_cs, ext_mem_we, ext_mem_data_o);
      end
      if (j < 3) step;
    end
    ext_mem_ack = 1'b1;
    #1;
    n_cmp++; if (i_ack !== 1'b1 || d_ack !== 1'b0) begin
      n_bad++; $display("FAIL wr_ack: got i=%b d=%b want 1/0", i_ack, d_ack);
    end
    step;
    ext_mem_ack = 1'b0; i_cs = 1'b0; i_we = 1'b0;
    step; step;
  endtask

  task automatic test_timeout;
    t_d_cs = 1'b1;
    step;
    for (int j = 1; j <= 7; j++) begin
      step;
      n_cmp++;
      if (t_mem_cs !== 1'b1 || t_d_err !== 1'b0) begin
        n_bad++; $display("FAIL to_busy_c%0d: got cs=%b err=%b want 1/0", j, t_mem_cs, t_d_err);
      end
    end
    step;
    n_cmp++; if (t_d_err !== 1'b1 || t_mem_cs !== 1'b0 || t_i_err !== 1'b0) begin
      n_bad++; $display("FAIL to_err: got d_err=%b cs=%b i_err=%b want 1/0/0", t_d_err, t_mem_cs, t_i_err);
    end
    t_d_cs = 1'b0; t_ack = 1'b1;
    #1;
    n_cmp++; if (t_d_ack !== 1'b0) begin n_bad++; $display("FAIL to_late_ack_gap: got %b want 0", t_d_ack); end
    step;
    n_cmp++; if (t_d_err !== 1'b0 || t_d_ack !== 1'b0) begin
      n_bad++; $display("FAIL to_after: got err=%b ack=%b want 0/0", t_d_err, t_d_ack);
    end
    step;
    t_ack = 1'b0;
    n_cmp++; if (t_mem_cs !== 1'b0) begin n_bad++; $display("FAIL to_idle_cs: got %b want 0", t_mem_cs); end
    step;
  endtask

  task automatic test_ack_at_timeout;
    t_d_cs = 1'b1;
    step;
    repeat (7) step;
    ext_mem_data_i = {8{32'h0BAD_F00D}};
    t_ack = 1'b1;
    #1;
    n_cmp++; if (t_d_ack !== 1'b1 || t_d_data_o !== {8{32'h0BAD_F00D}}) begin
      n_bad++; $display("FAIL tie_ack: got ack=%b data=%h want 1", t_d_ack, t_d_data_o);
    end
    step;
    t_ack = 1'b0; t_d_cs = 1'b0;
    n_cmp++; if (t_d_err !== 1'b0) begin n_bad++; $display("FAIL tie_no_err: got %b want 0", t_d_err); end
    step;
    n_cmp++; if (t_d_err !== 1'b0) begin n_bad++; $display("FAIL tie_no_err2: got %b want 0", t_d_err); end
    step;
  endtask

  task automatic test_reset_mid;
    d_addr = 32'h0000_0400; i_addr = 32'h0000_0800;
    d_cs = 1'b1;
    step;
    n_cmp++; if (ext_mem_cs !== 1'b1) begin n_bad++; $display("FAIL rmid_busy: got %b want 1", ext_mem_cs); end
    #3;
    rst = 1'b1;
    #1;
    n_cmp++; if (ext_mem_cs !== 1'b0 || ext_mem_addr !== 32'h0) begin
      n_bad++; $display("FAIL rmid_async: got cs=%b addr=%h want 0/0", ext_mem_cs, ext_mem_addr);
    end
    i_cs = 1'b1;
    step; step;
    rst = 1'b0;
    step;
    n_cmp++; if (ext_mem_cs !== 1'b1 || ext_mem_addr !== 32'h800) begin
      n_bad++; $display("FAIL rmid_regrant: got cs=%b addr=%h want 1/800", ext_mem_cs, ext_mem_addr);
    end
    ext_mem_ack = 1'b1;
    #1;
    n_cmp++; if (i_ack !== 1'b1 || d_ack !== 1'b0) begin
      n_bad++; $display("FAIL rmid_ack: got i=%b d=%b want 1/0", i_ack, d_ack);
    end
    step;
    ext_mem_ack = 1'b0; i_cs = 1'b0; d_cs = 1'b0;
    step; step;
  endtask

  task automatic test_abort;
    int d_acks;
    d_acks = 0;
    d_cs = 1'b1;
    step;
    i_cs = 1'b1;
    n_cmp++; if (ext_mem_addr !== 32'h400) begin n_bad++; $display("FAIL ab_owner: got %h want 400", ext_mem_addr); end
    step; step;
    d_cs = 1'b0;
    #1;
    if (d_ack === 1'b1) d_acks++;
    n_cmp++; if (ext_mem_cs !== 1'b0) begin n_bad++; $display("FAIL ab_cs_follow: got %b want 0", ext_mem_cs); end
    step;
    if (d_ack === 1'b1) d_acks++;
    n_cmp++; if (ext_mem_cs !== 1'b0) begin n_bad++; $display("FAIL ab_idle: got %b want 0", ext_mem_cs); end
    step;
    if (d_ack === 1'b1) d_acks++;
    n_cmp++; if (ext_mem_cs !== 1'b1 || ext_mem_addr !== 32'h800) begin
      n_bad++; $display("FAIL ab_next_grant: got cs=%b addr=%h want 1/800", ext_mem_cs, ext_mem_addr);
    end
    ext_mem_ack = 1'b1;
    #1;
    n_cmp++; if (i_ack !== 1'b1 || d_ack !== 1'b0 || d_acks !== 0) begin
      n_bad++; $display("FAIL ab_ack: got i=%b d=%b d_acks=%0d want 1/0/0", i_ack, d_ack, d_acks);
    end
    step;
    ext_mem_ack = 1'b0; i_cs = 1'b0;
    step; step;
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    rst = 1'b1;
    i_addr = '0; d_addr = '0; i_cs = 1'b0; d_cs = 1'b0; i_we = 1'b0; d_we = 1'b0;
    i_data_i = '0; d_data_i = '0; ext_mem_data_i = '0; ext_mem_ack = 1'b0;
    t_i_cs = 1'b0; t_d_cs = 1'b0; t_ack = 1'b0;
    test_reset;
    test_simultaneous;
    test_single_read;
    test_write;
    test_timeout;
    test_ack_at_timeout;
    test_reset_mid;
    test_abort;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
